// File: rtl/stage_sequencer.sv
// rtl/stage_sequencer.sv - multi-cycle IF/ID/EX/MEM/WB control FSM for the RV32I core
// Owns all stage latch enables, memory handshakes and architectural write enables.
module stage_sequencer #(
  parameter int unsigned MEM_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        stop_req,
  input  logic [6:0]  opcode,
  input  logic [4:0]  rd,
  input  logic        imem_ack,
  input  logic        dmem_ack,
  output logic        imem_req,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic        if_en,
  output logic        id_en,
  output logic        ex_en,
  output logic        mem_en,
  output logic        wb_en,
  output logic        rf_we,
  output logic        pc_we,
  output logic [2:0]  state,
  output logic        halted,
  output logic [1:0]  fault,
  output logic [31:0] instr_count
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_IF   = 3'd1,
    S_ID   = 3'd2,
    S_EX   = 3'd3,
    S_MEM  = 3'd4,
    S_WB   = 3'd5,
    S_HALT = 3'd6
  } state_t;

  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  localparam logic [1:0] F_NONE    = 2'd0;
  localparam logic [1:0] F_SYSTEM  = 2'd1;
  localparam logic [1:0] F_ILLEGAL = 2'd2;
  localparam logic [1:0] F_TIMEOUT = 2'd3;

  // Counter value seen in the last permitted wait cycle; an ack there still wins.
  localparam logic [7:0] TMO_LAST = 8'(MEM_TIMEOUT - 1);

  state_t      state_q, state_d;
  logic [6:0]  op_q, op_d;
  logic [4:0]  rd_q, rd_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [1:0]  fault_q, fault_d;
  logic [31:0] count_q, count_d;
  logic        tmo_hit;

  function automatic logic legal_op(input logic [6:0] op);
    case (op)
      OP_RTYPE, OP_ITYPE, OP_LOAD, OP_STORE, OP_BRANCH,
      OP_JAL, OP_JALR, OP_LUI, OP_AUIPC: legal_op = 1'b1;
      default:                           legal_op = 1'b0;
    endcase
  endfunction

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      op_q    <= '0;
      rd_q    <= '0;
      cnt_q   <= '0;
      fault_q <= F_NONE;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      rd_q    <= rd_d;
      cnt_q   <= cnt_d;
      fault_q <= fault_d;
      count_q <= count_d;
    end
  end

  assign tmo_hit = (cnt_q == TMO_LAST);

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    rd_d    = rd_q;
    fault_d = fault_q;
    count_d = count_q;
    case (state_q)
      S_IDLE: if (start) state_d = S_IF;
      S_IF: begin
        if (imem_ack) begin
          op_d    = opcode;
          rd_d    = rd;
          state_d = S_ID;
        end else if (tmo_hit) begin
          fault_d = F_TIMEOUT;
          state_d = S_HALT;
        end
      end
      S_ID: begin
        if (op_q == OP_SYSTEM) begin
          fault_d = F_SYSTEM;
          state_d = S_HALT;
        end else if (!legal_op(op_q)) begin
          fault_d = F_ILLEGAL;
          state_d = S_HALT;
        end else begin
          state_d = S_EX;
        end
      end
      S_EX: state_d = (op_q == OP_LOAD || op_q == OP_STORE) ? S_MEM : S_WB;
      S_MEM: begin
        if (dmem_ack) begin
          state_d = S_WB;
        end else if (tmo_hit) begin
          fault_d = F_TIMEOUT;
          state_d = S_HALT;
        end
      end
      S_WB: begin
        count_d = count_q + 32'd1;
        state_d = stop_req ? S_IDLE : S_IF;
      end
      S_HALT: state_d = S_HALT;
      default: state_d = S_IDLE;
    endcase

    if (state_d != state_q)
      cnt_d = '0;
    else if (state_q == S_IF || state_q == S_MEM)
      cnt_d = cnt_q + 8'd1;
    else
      cnt_d = cnt_q;
  end

  always_comb begin
    imem_req = 1'b0;
    dmem_req = 1'b0;
    dmem_we  = 1'b0;
    if_en    = 1'b0;
    id_en    = 1'b0;
    ex_en    = 1'b0;
    mem_en   = 1'b0;
    wb_en    = 1'b0;
    rf_we    = 1'b0;
    pc_we    = 1'b0;
    halted   = 1'b0;
    case (state_q)
      S_IF: begin
        imem_req = 1'b1;
        if_en    = imem_ack;
      end
      S_ID: id_en = 1'b1;
      S_EX: ex_en = 1'b1;
      S_MEM: begin
        dmem_req = 1'b1;
        dmem_we  = (op_q == OP_STORE);
        mem_en   = dmem_ack;
      end
      S_WB: begin
        wb_en = 1'b1;
        pc_we = 1'b1;
        rf_we = (op_q != OP_STORE) && (op_q != OP_BRANCH) && (rd_q != 5'd0);
      end
      S_HALT: halted = 1'b1;
      default: ;
    endcase
  end

  assign state       = state_q;
  assign fault       = fault_q;
  assign instr_count = count_q;

endmodule

// File: tb/tb_stage_sequencer.sv
// tb/tb_stage_sequencer.sv - directed self-checking bench for stage_sequencer
module tb_stage_sequencer;

  logic        clk = 1'b0;
  logic        rst, start, stop_req, imem_ack, dmem_ack;
  logic [6:0]  opcode;
  logic [4:0]  rd;
  logic        imem_req, dmem_req, dmem_we, if_en, id_en, ex_en, mem_en, wb_en;
  logic        rf_we, pc_we, halted;
  logic [2:0]  state;
  logic [1:0]  fault;
  logic [31:0] instr_count;

  int checks = 0;
  int failures = 0;
  int pc_pulses = 0;
  int rf_pulses = 0;
  int pc_snap;

  localparam logic [10:0] IMQ = 11'b100_0000_0000;
  localparam logic [10:0] DMQ = 11'b010_0000_0000;
  localparam logic [10:0] DWE = 11'b001_0000_0000;
  localparam logic [10:0] IFE = 11'b000_1000_0000;
  localparam logic [10:0] IDE = 11'b000_0100_0000;
  localparam logic [10:0] EXE = 11'b000_0010_0000;
  localparam logic [10:0] MEE = 11'b000_0001_0000;
  localparam logic [10:0] WBE = 11'b000_0000_1000;
  localparam logic [10:0] RFW = 11'b000_0000_0100;
  localparam logic [10:0] PCW = 11'b000_0000_0010;
  localparam logic [10:0] HLT = 11'b000_0000_0001;

  localparam logic [6:0] ADD   = 7'b0110011;
  localparam logic [6:0] ADDI  = 7'b0010011;
  localparam logic [6:0] LW    = 7'b0000011;
  localparam logic [6:0] SW    = 7'b0100011;
  localparam logic [6:0] BEQ   = 7'b1100011;
  localparam logic [6:0] ECALL = 7'b1110011;

  stage_sequencer #(.MEM_TIMEOUT(16)) dut (
    .clk(clk), .rst(rst), .start(start), .stop_req(stop_req),
    .opcode(opcode), .rd(rd), .imem_ack(imem_ack), .dmem_ack(dmem_ack),
    .imem_req(imem_req), .dmem_req(dmem_req), .dmem_we(dmem_we),
    .if_en(if_en), .id_en(id_en), .ex_en(ex_en), .mem_en(mem_en), .wb_en(wb_en),
    .rf_we(rf_we), .pc_we(pc_we), .state(state), .halted(halted),
    .fault(fault), .instr_count(instr_count)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (pc_we) pc_pulses++;
    if (rf_we) rf_pulses++;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [10:0] outs();
    return {imem_req, dmem_req, dmem_we, if_en, id_en, ex_en, mem_en, wb_en, rf_we, pc_we, halted};
  endfunction

  task automatic look(input string tag, input logic [2:0] es, input logic [10:0] eo);
    check({tag, ".state"}, 32'(state), 32'(es));
    check({tag, ".outs"}, 32'(outs()), 32'(eo));
  endtask

  // Settle inputs, check this cycle, then advance to just after the next edge.
  task automatic cyc(input string tag, input logic [2:0] es, input logic [10:0] eo);
    #1;
    look(tag, es, eo);
    @(posedge clk);
    #1;
  endtask

  task automatic run_instr(input string tag, input logic [6:0] op, input logic [4:0] r,
                           input logic is_mem, input logic exp_rf);
    opcode = op; rd = r; imem_ack = 1'b1;
    cyc({tag, "_if"}, 3'd1, IMQ | IFE);
    imem_ack = 1'b0; opcode = 7'h7f; rd = 5'd31;
    cyc({tag, "_id"}, 3'd2, IDE);
    cyc({tag, "_ex"}, 3'd3, EXE);
    if (is_mem) begin
      dmem_ack = 1'b1;
      cyc({tag, "_mem"}, 3'd4, DMQ | MEE | ((op == SW) ? DWE : 11'd0));
      dmem_ack = 1'b0;
    end
    cyc({tag, "_wb"}, 3'd5, WBE | PCW | (exp_rf ? RFW : 11'd0));
  endtask

  task automatic do_reset();
    rst = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1; start = 1'b1;
    cyc("rst_start", 3'd0, 11'd0);
    start = 1'b0;
  endtask

  initial begin
    rst = 1'b0; start = 1'b0; stop_req = 1'b0; imem_ack = 1'b0; dmem_ack = 1'b0;
    opcode = 7'd0; rd = 5'd0;
    repeat (3) @(posedge clk);
    #1;
    look("reset", 3'd0, 11'd0);
    check("reset.fault", 32'(fault), 32'd0);
    check("reset.count", instr_count, 32'd0);

    rst = 1'b1;
    cyc("idle_hold", 3'd0, 11'd0);
    start = 1'b1;
    cyc("idle_start", 3'd0, 11'd0);
    start = 1'b0;

    // ADD x5 with immediate ack; stray dmem_ack in ID must be ignored
    opcode = ADD; rd = 5'd5; imem_ack = 1'b1;
    cyc("add_if", 3'd1, IMQ | IFE);
    imem_ack = 1'b0; opcode = ECALL; rd = 5'd0; dmem_ack = 1'b1;
    cyc("add_id", 3'd2, IDE);
    dmem_ack = 1'b0;
    cyc("add_ex", 3'd3, EXE);
    cyc("add_wb", 3'd5, WBE | RFW | PCW);
    #1;
    look("add_next", 3'd1, IMQ);
    check("add.count", instr_count, 32'd1);

    // LW with dmem_ack three cycles late: 8-cycle instruction
    opcode = LW; rd = 5'd3; imem_ack = 1'b1;
    cyc("lw_if", 3'd1, IMQ | IFE);
    imem_ack = 1'b0;
    cyc("lw_id", 3'd2, IDE);
    cyc("lw_ex", 3'd3, EXE);
    repeat (3) cyc("lw_wait", 3'd4, DMQ);
    dmem_ack = 1'b1;
    cyc("lw_ack", 3'd4, DMQ | MEE);
    dmem_ack = 1'b0;
    cyc("lw_wb", 3'd5, WBE | RFW | PCW);
    check("lw.count", instr_count, 32'd2);

    run_instr("sw", SW, 5'd7, 1'b1, 1'b0);
    run_instr("beq", BEQ, 5'd9, 1'b0, 1'b0);
    stop_req = 1'b1;
    run_instr("addi", ADDI, 5'd0, 1'b0, 1'b0);
    stop_req = 1'b0;
    cyc("stopped", 3'd0, 11'd0);
    check("trio.count", instr_count, 32'd5);
    check("trio.pc_pulses", 32'(pc_pulses), 32'd5);
    check("trio.rf_pulses", 32'(rf_pulses), 32'd2);

    // Reset in the second MEM cycle of a store
    start = 1'b1;
    cyc("restart", 3'd0, 11'd0);
    start = 1'b0;
    opcode = SW; rd = 5'd1; imem_ack = 1'b1;
    cyc("rsw_if", 3'd1, IMQ | IFE);
    imem_ack = 1'b0;
    cyc("rsw_id", 3'd2, IDE);
    cyc("rsw_ex", 3'd3, EXE);
    cyc("rsw_mem1", 3'd4, DMQ | DWE);
    #1;
    look("rsw_mem2", 3'd4, DMQ | DWE);
    rst = 1'b0;
    #1;
    look("rsw_async", 3'd0, 11'd0);
    check("rsw.count", instr_count, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b1; start = 1'b1;
    cyc("rsw_resume", 3'd0, 11'd0);
    start = 1'b0;
    #1;
    look("rsw_fetch", 3'd1, IMQ);
    run_instr("post", ADD, 5'd1, 1'b0, 1'b1);
    check("post.count", instr_count, 32'd1);

    // Ack arriving in the 16th MEM cycle still wins over the timeout
    opcode = LW; rd = 5'd2; imem_ack = 1'b1;
    cyc("edge_if", 3'd1, IMQ | IFE);
    imem_ack = 1'b0;
    cyc("edge_id", 3'd2, IDE);
    cyc("edge_ex", 3'd3, EXE);
    repeat (15) cyc("edge_wait", 3'd4, DMQ);
    dmem_ack = 1'b1;
    cyc("edge_ack", 3'd4, DMQ | MEE);
    dmem_ack = 1'b0;
    cyc("edge_wb", 3'd5, WBE | RFW | PCW);
    check("edge.fault", 32'(fault), 32'd0);

    // dmem_ack never arrives
    opcode = LW; rd = 5'd4; imem_ack = 1'b1;
    cyc("tmo_if", 3'd1, IMQ | IFE);
    imem_ack = 1'b0;
    cyc("tmo_id", 3'd2, IDE);
    cyc("tmo_ex", 3'd3, EXE);
    repeat (16) cyc("tmo_wait", 3'd4, DMQ);
    #1;
    look("tmo_halt", 3'd6, HLT);
    check("tmo.fault", 32'(fault), 32'd3);
    check("tmo.count", instr_count, 32'd2);

    // imem_ack never arrives
    do_reset();
    repeat (16) cyc("itmo_wait", 3'd1, IMQ);
    #1;
    look("itmo_halt", 3'd6, HLT);
    check("itmo.fault", 32'(fault), 32'd3);

    // Illegal opcode
    do_reset();
    opcode = 7'b0000000; rd = 5'd1; imem_ack = 1'b1;
    cyc("ill_if", 3'd1, IMQ | IFE);
    imem_ack = 1'b0;
    cyc("ill_id", 3'd2, IDE);
    #1;
    look("ill_halt", 3'd6, HLT);
    check("ill.fault", 32'(fault), 32'd2);

    // ECALL halts; HALT ignores start, acks and stop_req
    do_reset();
    opcode = ECALL; rd = 5'd0; imem_ack = 1'b1;
    cyc("ecall_if", 3'd1, IMQ | IFE);
    imem_ack = 1'b0;
    cyc("ecall_id", 3'd2, IDE);
    pc_snap = pc_pulses;
    start = 1'b1; imem_ack = 1'b1; dmem_ack = 1'b1; stop_req = 1'b1; opcode = ADD; rd = 5'd3;
    repeat (20) cyc("ecall_hold", 3'd6, HLT);
    check("ecall.fault", 32'(fault), 32'd1);
    check("ecall.count", instr_count, 32'd0);
    check("ecall.pc_pulses", 32'(pc_pulses), 32'(pc_snap));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
